// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies and the IDLE/RUN state type.
package md_unit_ctrl_pkg;

  // md_op encodings; 6 and 7 are no-ops.
  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5
  } md_op_e;

  localparam int unsigned MultLatDef = 5;
  localparam int unsigned DivLatDef  = 10;

  // IDLE when the busy counter is zero, RUN otherwise.
  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 32x32 multiply and divide, signed or unsigned by op.
// Division uses magnitudes so INT_MIN / -1 wraps to INT_MIN without a trap.
module md_unit_ctrl_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Product on sign/zero-extended operands; the low 64 bits are exact either way.
  always_comb begin
    is_signed = (op == MdMult) || (op == MdDiv);
    is_div    = (op == MdDiv) || (op == MdDivu);
    a_ext     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod      = a_ext * b_ext;

    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
    div0  = (b == 32'd0);
    // Substitute a divisor of 1 so the divider never sees zero; result is discarded.
    b_div = div0 ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO ownership, fixed-latency busy
// counter, pending result staging and the D-stage stall request.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDef,
  parameter int unsigned DIV_LAT  = DivLatDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_skip_q, pend_skip_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            div0;
  logic            issue;
  md_state_e       state;

  md_unit_ctrl_arith u_arith (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign state    = (cnt_q != '0) ? StRun : StIdle;
  assign issue    = start & ~cancel;
  assign busy     = (cnt_q != '0);
  assign md_stall = d_is_md & (busy | (issue & (md_op <= 3'd3)));
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Next state: launch/move at IDLE, count down and commit at RUN.
  always_comb begin
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_skip_d = pend_skip_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state)
      StIdle: begin
        if (issue) begin
          case (md_op)
            MdMult, MdMultu: begin
              pend_hi_d   = res_hi;
              pend_lo_d   = res_lo;
              pend_skip_d = 1'b0;
              cnt_d       = CntW'(MULT_LAT);
            end
            MdDiv, MdDivu: begin
              pend_hi_d   = res_hi;
              pend_lo_d   = res_lo;
              pend_skip_d = div0;
              cnt_d       = CntW'(DIV_LAT);
            end
            MdMthi:  hi_d = rs_val;
            MdMtlo:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Any start here is held in D by md_stall and ignored; cancel cannot abort.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1) && !pend_skip_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_skip_q <= pend_skip_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, results, div-by-zero, cancel,
// stall, ignored starts while running, and asynchronous reset.
module tb_md_unit_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cancel   (cancel),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    md_op   = 3'd0;
    rs_val  = 32'd3;
    rt_val  = 32'd4;
    cancel  = 1'b0;
    d_is_md = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_start: md_stall=%b expected 1", md_stall);
    end
    start = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle: md_stall=%b expected 0", md_stall);
    end
    d_is_md = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic test_arith();
    vec_t v[8];
    v[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE};
    v[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3] = '{3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3};
    v[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000};
    v[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0};
    v[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD};
    v[7] = '{3'd1, 32'h1234_5678, 32'h10, 5, 32'd1, 32'h2345_6780};
    for (int n = 0; n < 8; n++) begin
      start  = 1'b1;
      md_op  = v[n].op;
      rs_val = v[n].a;
      rt_val = v[n].b;
      step();
      start = 1'b0;
      for (int c = 1; c <= v[n].lat; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          errors++;
          $display("FAIL arith%0d_busy_c%0d: busy=%b hi=%h lo=%h expected 1 %h %h",
                   n, c, busy, hi, lo, m_hi, m_lo);
        end
        step();
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== v[n].ehi || lo !== v[n].elo) begin
        errors++;
        $display("FAIL arith%0d_result: busy=%b hi=%h lo=%h expected 0 %h %h",
                 n, busy, hi, lo, v[n].ehi, v[n].elo);
      end
      m_hi = v[n].ehi;
      m_lo = v[n].elo;
      step();
    end
  endtask

  task automatic test_div0();
    start  = 1'b1;
    md_op  = 3'd4;
    rs_val = 32'h11;
    step();
    md_op  = 3'd5;
    rs_val = 32'h22;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h11 || lo !== m_lo) begin
      errors++;
      $display("FAIL mthi: busy=%b hi=%h lo=%h expected 0 00000011 %h", busy, hi, lo, m_lo);
    end
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h expected 0 00000011 00000022", busy, hi, lo);
    end
    m_hi = 32'h11;
    m_lo = 32'h22;
    step();
    start  = 1'b1;
    md_op  = 3'd3;
    rs_val = 32'd7;
    rt_val = 32'd0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL div0_busy_c%0d: busy=%b expected 1", c, busy);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL div0_keep: busy=%b hi=%h lo=%h expected 0 00000011 00000022", busy, hi, lo);
    end
    step();
  endtask

  task automatic test_cancel();
    start   = 1'b1;
    cancel  = 1'b1;
    d_is_md = 1'b1;
    md_op   = 3'd0;
    rs_val  = 32'd9;
    rt_val  = 32'd9;
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stall: md_stall=%b expected 0", md_stall);
    end
    step();
    start   = 1'b0;
    cancel  = 1'b0;
    d_is_md = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cancel_start: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
    step();
    // Cancel during RUN must not abort the op.
    start  = 1'b1;
    md_op  = 3'd1;
    rs_val = 32'd6;
    rt_val = 32'd7;
    step();
    start  = 1'b0;
    cancel = 1'b1;
    repeat (5) step();
    cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL cancel_run: busy=%b hi=%h lo=%h expected 0 00000000 0000002a", busy, hi, lo);
    end
    m_hi = 32'd0;
    m_lo = 32'd42;
    step();
  endtask

  task automatic test_stall();
    start   = 1'b1;
    d_is_md = 1'b1;
    md_op   = 3'd2;
    rs_val  = 32'd100;
    rt_val  = 32'd7;
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue: md_stall=%b expected 1", md_stall);
    end
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (md_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy_c%0d: md_stall=%b expected 1", c, md_stall);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL stall_release: md_stall=%b hi=%h lo=%h expected 0 00000002 0000000e",
               md_stall, hi, lo);
    end
    step();
    start  = 1'b1;
    md_op  = 3'd4;
    rs_val = 32'hABCD;
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_mthi: md_stall=%b expected 0", md_stall);
    end
    step();
    start   = 1'b0;
    d_is_md = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'hABCD || lo !== 32'd14) begin
      errors++;
      $display("FAIL mthi_abcd: busy=%b hi=%h lo=%h expected 0 0000abcd 0000000e", busy, hi, lo);
    end
    m_hi = 32'hABCD;
    m_lo = 32'd14;
    step();
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    start  = 1'b1;
    md_op  = 3'd1;
    rs_val = 32'd3;
    rt_val = 32'd4;
    step();
    busy_cnt = 0;
    // Starts while running (MTHI, then DIV) must be ignored.
    for (int c = 1; c <= 7; c++) begin
      start  = (c == 2 || c == 3);
      md_op  = (c == 2) ? 3'd4 : 3'd2;
      rs_val = 32'hDEAD;
      rt_val = 32'd1;
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      step();
    end
    start = 1'b0;
    checks++;
    if (busy_cnt !== 5 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL start_in_run: busy_cycles=%0d hi=%h lo=%h expected 5 00000000 0000000c",
               busy_cnt, hi, lo);
    end
    // Issue immediately in the cycle busy falls.
    start  = 1'b1;
    md_op  = 3'd1;
    rs_val = 32'd5;
    rt_val = 32'd5;
    step();
    start  = 1'b1;
    md_op  = 3'd1;
    rs_val = 32'd8;
    rt_val = 32'd8;
    repeat (4) step();
    start = 1'b0;
    step();
    start  = 1'b1;
    md_op  = 3'd5;
    rs_val = 32'h77;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd25) begin
      errors++;
      $display("FAIL back_to_back: busy=%b hi=%h lo=%h expected 0 00000000 00000019", busy, hi, lo);
    end
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h77) begin
      errors++;
      $display("FAIL mtlo_after: hi=%h lo=%h expected 00000000 00000077", hi, lo);
    end
    m_hi = 32'd0;
    m_lo = 32'h77;
    step();
  endtask

  task automatic test_reset_mid();
    start  = 1'b1;
    md_op  = 3'd3;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    step();
    start = 1'b0;
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_arith();
    test_div0();
    test_cancel();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
